// File: rtl/mode_output_scheduler.sv
// Grants the buzzer/song-memory datapath to one of free, auto or learn engines, with debounced switching, mute and restart.
// Outputs are registered with 1-cycle latency; there is no backpressure, engines are granted rather than handshaked.
module mode_output_scheduler #(
   parameter int STABLE_CYCLES = 2_000_000,
   parameter int MUTE_CYCLES   = 5_000_000,
   parameter int CNT_W         = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode_sel,
   input  logic       free_key_on,
   input  logic [3:0] free_key,
   input  logic       auto_key_on,
   input  logic [3:0] auto_key,
   input  logic [4:0] auto_addr,
   input  logic       learn_key_on,
   input  logic [3:0] learn_key,
   input  logic [4:0] learn_addr,
   output logic       key_on,
   output logic [3:0] key,
   output logic [4:0] mem_addr,
   output logic [1:0] active_mode,
   output logic [2:0] mode_rst_n,
   output logic       switching
);

   typedef enum logic [1:0] {ACTIVE, DEBOUNCE, MUTE, RESTART} state_t;

   localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MUTE_LOAD   = CNT_W'(MUTE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state, state_nxt;
   logic [1:0]       cand, cand_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             key_on_nxt;
   logic [3:0]       key_nxt;
   logic [4:0]       mem_addr_nxt;
   logic             sel_valid;

   assign sel_valid = (mode_sel != 2'b11);

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      case (state)
         ACTIVE: begin
            if (sel_valid && mode_sel != active_mode) begin
               state_nxt = DEBOUNCE;
               cand_nxt  = mode_sel;
               cnt_nxt   = STABLE_LOAD;
            end
         end
         DEBOUNCE: begin
            if (mode_sel == cand) begin
               if (cnt == '0) begin
                  state_nxt = MUTE;
                  cnt_nxt   = MUTE_LOAD;
               end else begin
                  cnt_nxt = cnt - CNT_ONE;
               end
            end else if (!sel_valid || mode_sel == active_mode) begin
               state_nxt = ACTIVE;
            end else begin
               // Request moved to a third mode: restart the stability window on it.
               cand_nxt = mode_sel;
               cnt_nxt  = STABLE_LOAD;
            end
         end
         MUTE: begin
            if (cnt == '0) state_nxt = RESTART;
            else           cnt_nxt   = cnt - CNT_ONE;
         end
         RESTART: state_nxt = ACTIVE;
         default: state_nxt = RESTART;
      endcase
   end

   // The old engine keeps the datapath through debounce so a rejected glitch is inaudible.
   always_comb begin
      key_on_nxt   = 1'b0;
      key_nxt      = 4'd0;
      mem_addr_nxt = 5'd0;
      if (state == ACTIVE || state == DEBOUNCE) begin
         case (active_mode)
            2'b00: begin
               key_on_nxt = free_key_on;
               key_nxt    = free_key;
            end
            2'b01: begin
               key_on_nxt   = auto_key_on;
               key_nxt      = auto_key;
               mem_addr_nxt = auto_addr;
            end
            2'b10: begin
               key_on_nxt   = learn_key_on;
               key_nxt      = learn_key;
               mem_addr_nxt = learn_addr;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mode_rst_n = 3'b111;
      if (!rst) begin
         mode_rst_n = 3'b000;
      end else if (state == RESTART) begin
         case (cand)
            2'b00:   mode_rst_n = 3'b110;
            2'b01:   mode_rst_n = 3'b101;
            2'b10:   mode_rst_n = 3'b011;
            default: mode_rst_n = 3'b111;
         endcase
      end
   end

   assign switching = (state != ACTIVE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RESTART;
         cand        <= 2'b00;
         cnt         <= '0;
         active_mode <= 2'b00;
         key_on      <= 1'b0;
         key         <= 4'd0;
         mem_addr    <= 5'd0;
      end else begin
         state    <= state_nxt;
         cand     <= cand_nxt;
         cnt      <= cnt_nxt;
         key_on   <= key_on_nxt;
         key      <= key_nxt;
         mem_addr <= mem_addr_nxt;
         if (state == RESTART) active_mode <= cand;
      end
   end

endmodule

// File: tb/tb_mode_output_scheduler.sv
module tb_mode_output_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode_sel;
   logic       free_key_on, auto_key_on, learn_key_on;
   logic [3:0] free_key, auto_key, learn_key;
   logic [4:0] auto_addr, learn_addr;
   logic       key_on;
   logic [3:0] key;
   logic [4:0] mem_addr;
   logic [1:0] active_mode;
   logic [2:0] mode_rst_n;
   logic       switching;

   int n_checks = 0;
   int n_fail   = 0;

   mode_output_scheduler #(.STABLE_CYCLES(4), .MUTE_CYCLES(3), .CNT_W(23)) dut (
      .clk(clk), .rst(rst), .mode_sel(mode_sel),
      .free_key_on(free_key_on), .free_key(free_key),
      .auto_key_on(auto_key_on), .auto_key(auto_key), .auto_addr(auto_addr),
      .learn_key_on(learn_key_on), .learn_key(learn_key), .learn_addr(learn_addr),
      .key_on(key_on), .key(key), .mem_addr(mem_addr),
      .active_mode(active_mode), .mode_rst_n(mode_rst_n), .switching(switching)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mode_sel = 2'b00;
      free_key_on = 1'b0; free_key = 4'd0;
      auto_key_on = 1'b0; auto_key = 4'd0; auto_addr = 5'd0;
      learn_key_on = 1'b0; learn_key = 4'd0; learn_addr = 5'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (mode_rst_n !== 3'b000 || switching !== 1'b1 || key_on !== 1'b0 || active_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: rst_n=%b sw=%b key_on=%b mode=%b, want 000 1 0 00",
                     mode_rst_n, switching, key_on, active_mode);
         end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (mode_rst_n !== 3'b110) begin
         n_fail++;
         $display("FAIL reset_restart_pulse: rst_n=%b want 110", mode_rst_n);
      end
      tick();
      n_checks++;
      if (mode_rst_n !== 3'b111 || switching !== 1'b0 || active_mode !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_granted: rst_n=%b sw=%b mode=%b want 111 0 00", mode_rst_n, switching, active_mode);
      end
   endtask

   task automatic test_free_passthrough();
      free_key = 4'd5; free_key_on = 1'b1;
      auto_addr = 5'd9; learn_addr = 5'd7;
      tick();
      n_checks++;
      if (key !== 4'd5 || key_on !== 1'b1 || mem_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL free_pass: key=%0d on=%b addr=%0d want 5 1 0", key, key_on, mem_addr);
      end
      free_key = 4'd11; free_key_on = 1'b0;
      tick();
      n_checks++;
      if (key !== 4'd11 || key_on !== 1'b0) begin
         n_fail++;
         $display("FAIL free_pass2: key=%0d on=%b want 11 0", key, key_on);
      end
      free_key = 4'd5; free_key_on = 1'b1;
      tick();
   endtask

   task automatic test_clean_switch();
      learn_key = 4'd9; learn_key_on = 1'b1; learn_addr = 5'd7;
      mode_sel = 2'b10;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++;
         if (switching !== 1'b1 || active_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL switch_busy[%0d]: sw=%b mode=%b want 1 00", i, switching, active_mode);
         end
         if (i <= 4) begin
            n_checks++;
            if (key_on !== 1'b1 || key !== 4'd5) begin
               n_fail++;
               $display("FAIL switch_old_follow[%0d]: on=%b key=%0d want 1 5", i, key_on, key);
            end
         end
         if (i >= 6) begin
            n_checks++;
            if (key_on !== 1'b0 || key !== 4'd0) begin
               n_fail++;
               $display("FAIL switch_mute[%0d]: on=%b key=%0d want 0 0", i, key_on, key);
            end
         end
         n_checks++;
         if (mode_rst_n !== ((i == 8) ? 3'b011 : 3'b111)) begin
            n_fail++;
            $display("FAIL switch_rst_n[%0d]: got %b", i, mode_rst_n);
         end
      end
      tick();
      n_checks++;
      if (active_mode !== 2'b10 || switching !== 1'b0 || mode_rst_n !== 3'b111 || key_on !== 1'b0) begin
         n_fail++;
         $display("FAIL switch_grant: mode=%b sw=%b rst_n=%b on=%b want 10 0 111 0",
                  active_mode, switching, mode_rst_n, key_on);
      end
      tick();
      n_checks++;
      if (key !== 4'd9 || key_on !== 1'b1 || mem_addr !== 5'd7) begin
         n_fail++;
         $display("FAIL learn_pass: key=%0d on=%b addr=%0d want 9 1 7", key, key_on, mem_addr);
      end
      learn_addr = 5'd12;
      tick();
      n_checks++;
      if (mem_addr !== 5'd12) begin
         n_fail++;
         $display("FAIL learn_addr_track: addr=%0d want 12", mem_addr);
      end
   endtask

   task automatic test_glitch_and_reserved();
      mode_sel = 2'b01;
      tick();
      n_checks++;
      if (switching !== 1'b1) begin
         n_fail++;
         $display("FAIL glitch_debounce: sw=%b want 1", switching);
      end
      tick();
      mode_sel = 2'b10;
      tick();
      n_checks++;
      if (switching !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_abort: sw=%b want 0", switching);
      end
      mode_sel = 2'b11;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (active_mode !== 2'b10 || mode_rst_n !== 3'b111 || switching !== 1'b0 || key_on !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_reserved_hold[%0d]: mode=%b rst_n=%b sw=%b on=%b want 10 111 0 1",
                     i, active_mode, mode_rst_n, switching, key_on);
         end
      end
   endtask

   task automatic test_retarget();
      mode_sel = 2'b01;
      tick();
      tick();
      mode_sel = 2'b00;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i == 7) begin
            n_checks++;
            if (switching !== 1'b1 || active_mode !== 2'b10) begin
               n_fail++;
               $display("FAIL retarget_wait: sw=%b mode=%b want 1 10", switching, active_mode);
            end
         end
         if (i == 8) begin
            n_checks++;
            if (mode_rst_n !== 3'b110) begin
               n_fail++;
               $display("FAIL retarget_restart: rst_n=%b want 110", mode_rst_n);
            end
         end
      end
      n_checks++;
      if (active_mode !== 2'b00 || switching !== 1'b0) begin
         n_fail++;
         $display("FAIL retarget_grant: mode=%b sw=%b want 00 0", active_mode, switching);
      end
   endtask

   task automatic test_auto_switch();
      auto_key = 4'd3; auto_key_on = 1'b1; auto_addr = 5'd19;
      mode_sel = 2'b01;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i == 8) begin
            n_checks++;
            if (mode_rst_n !== 3'b101) begin
               n_fail++;
               $display("FAIL auto_restart: rst_n=%b want 101", mode_rst_n);
            end
         end
      end
      tick();
      n_checks++;
      if (active_mode !== 2'b01 || key !== 4'd3 || key_on !== 1'b1 || mem_addr !== 5'd19) begin
         n_fail++;
         $display("FAIL auto_pass: mode=%b key=%0d on=%b addr=%0d want 01 3 1 19",
                  active_mode, key, key_on, mem_addr);
      end
   endtask

   task automatic test_reset_mid_mute();
      mode_sel = 2'b10;
      for (int i = 0; i < 6; i++) tick();
      n_checks++;
      if (key_on !== 1'b0 || switching !== 1'b1) begin
         n_fail++;
         $display("FAIL midmute_in_mute: on=%b sw=%b want 0 1", key_on, switching);
      end
      rst = 1'b0;
      mode_sel = 2'b00;
      tick();
      n_checks++;
      if (key_on !== 1'b0 || active_mode !== 2'b00 || mode_rst_n !== 3'b000 || switching !== 1'b1) begin
         n_fail++;
         $display("FAIL midmute_reset: on=%b mode=%b rst_n=%b sw=%b want 0 00 000 1",
                  key_on, active_mode, mode_rst_n, switching);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (mode_rst_n !== 3'b110) begin
         n_fail++;
         $display("FAIL midmute_regrant_pulse: rst_n=%b want 110", mode_rst_n);
      end
      tick();
      tick();
      n_checks++;
      if (active_mode !== 2'b00 || switching !== 1'b0 || key !== 4'd5 || key_on !== 1'b1) begin
         n_fail++;
         $display("FAIL midmute_free_back: mode=%b sw=%b key=%0d on=%b want 00 0 5 1",
                  active_mode, switching, key, key_on);
      end
   endtask

   initial begin
      test_reset();
      test_free_passthrough();
      test_clean_switch();
      test_glitch_and_reserved();
      test_retarget();
      test_auto_switch();
      test_reset_mid_mute();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
